// File: rtl/mem_dev_dstb_pkg.sv
// Shared definitions for the MEM-stage device distributor.
// Contents: response codes, FSM state encoding, CLINT register region
// constants used as default device regions, latched request struct, and a
// region-hit helper.
package mem_dev_dstb_pkg;

  localparam logic [1:0] DSTB_RESP_OKAY   = 2'b00;
  localparam logic [1:0] DSTB_RESP_SLVERR = 2'b10;
  localparam logic [1:0] DSTB_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } dstb_state_e;

  // CLINT mtimecmp / mtime, each an 8-byte register.
  localparam logic [63:0] CLINT_MTIMECMP_BASE = 64'h0000_0000_0200_4000;
  localparam logic [63:0] CLINT_MTIME_BASE    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] CLINT_REG_MASK      = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        req;
  } dstb_req_t;

  function automatic logic region_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_dev_decode.sv
// Combinational address decoder for the device distributor.
// Ports: addr (byte address) -> hit (some device owns it), sel (one-hot
// target). Lowest matching index among 1..NUM_DEV-1 wins; device 0 is the
// fallback (DEFAULT_DEV0=1) or must match its own region (DEFAULT_DEV0=0).
module mem_dev_decode
  import mem_dev_dstb_pkg::*;
#(
  parameter int                      NUM_DEV      = 3,
  parameter logic [64*NUM_DEV-1:0]   DEV_BASE     = {CLINT_MTIME_BASE, CLINT_MTIMECMP_BASE, 64'h0},
  parameter logic [64*NUM_DEV-1:0]   DEV_MASK     = {CLINT_REG_MASK, CLINT_REG_MASK, 64'h0},
  parameter bit                      DEFAULT_DEV0 = 1'b1
) (
  input  logic [63:0]        addr,
  output logic               hit,
  output logic [NUM_DEV-1:0] sel
);

  logic [NUM_DEV-1:0] match;

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_match
    assign match[i] = region_hit(addr, DEV_BASE[64*i +: 64], DEV_MASK[64*i +: 64]);
  end

  always_comb begin
    hit = 1'b0;
    sel = '0;
    // Walk downwards so the lowest matching index overwrites higher ones.
    for (int i = NUM_DEV - 1; i >= 1; i--) begin
      if (match[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
    if (!hit && (DEFAULT_DEV0 || match[0])) begin
      sel[0] = 1'b1;
      hit    = 1'b1;
    end
  end

endmodule

// File: rtl/mem_dev_dstb.sv
// MEM-stage request distributor: routes one LSU request to one of NUM_DEV
// devices (0 = main memory), holds the request on the shared device buses
// until the target completes, and answers unmapped addresses with DECERR.
// Upstream: dstb_valid_i/addr/data_write/size/req in; ready pulse with
//   data_read/resp/skip_o out.
// Downstream: one-hot dstb_dev_valid_o, shared latched addr/data/size/req;
//   per-device ready/data_read/resp in.
// Optional macro DSTB_TIMEOUT_EN: adds TIMEOUT_CYCLES; a BUSY wait that long
//   without target ready completes with SLVERR.
module mem_dev_dstb
  import mem_dev_dstb_pkg::*;
#(
  parameter int                    NUM_DEV        = 3,
  parameter logic [64*NUM_DEV-1:0] DEV_BASE       = {CLINT_MTIME_BASE, CLINT_MTIMECMP_BASE, 64'h0},
  parameter logic [64*NUM_DEV-1:0] DEV_MASK       = {CLINT_REG_MASK, CLINT_REG_MASK, 64'h0},
  parameter bit                    DEFAULT_DEV0   = 1'b1,
  parameter logic [NUM_DEV-1:0]    SKIP_MASK      = 3'b110
`ifdef DSTB_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dstb_valid_i,
  output logic                    dstb_ready_o,
  output logic [63:0]             dstb_data_read_o,
  input  logic [63:0]             dstb_data_write_i,
  input  logic [63:0]             dstb_addr_i,
  input  logic [1:0]              dstb_size_i,
  output logic [1:0]              dstb_resp_o,
  input  logic                    dstb_req_i,
  output logic [NUM_DEV-1:0]      dstb_dev_valid_o,
  input  logic [NUM_DEV-1:0]      dstb_dev_ready_i,
  input  logic [64*NUM_DEV-1:0]   dstb_dev_data_read_i,
  output logic [63:0]             dstb_dev_data_write_o,
  output logic [63:0]             dstb_dev_addr_o,
  output logic [1:0]              dstb_dev_size_o,
  input  logic [2*NUM_DEV-1:0]    dstb_dev_resp_i,
  output logic                    dstb_dev_req_o,
  output logic                    skip_o
);

  dstb_state_e        state;
  dstb_req_t          req_q;
  logic [NUM_DEV-1:0] sel_q;     // non-zero only while BUSY
  logic               dec_hit;
  logic [NUM_DEV-1:0] dec_sel;
  logic               tgt_rdy;
  logic               tmo;
  logic [63:0]        rdata_mux;
  logic [1:0]         resp_mux;

  mem_dev_decode #(
    .NUM_DEV      (NUM_DEV),
    .DEV_BASE     (DEV_BASE),
    .DEV_MASK     (DEV_MASK),
    .DEFAULT_DEV0 (DEFAULT_DEV0)
  ) u_decode (
    .addr (dstb_addr_i),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // sel_q gates this, so non-target ready bits never complete a request.
  assign tgt_rdy = |(dstb_dev_ready_i & sel_q);

`ifdef DSTB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;
  // Target ready in the limit cycle takes priority over the timeout.
  assign tmo              = (state == ST_BUSY) && (tmo_cnt == TMO_LIMIT) && !tgt_rdy;
  assign dstb_dev_valid_o = sel_q & {NUM_DEV{~tmo}};
`else
  assign tmo              = 1'b0;
  assign dstb_dev_valid_o = sel_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      req_q <= '0;
      sel_q <= '0;
`ifdef DSTB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (dstb_valid_i) begin
            if (dec_hit) begin
              req_q <= '{addr: dstb_addr_i, wdata: dstb_data_write_i,
                         size: dstb_size_i, req: dstb_req_i};
              sel_q <= dec_sel;
              state <= ST_BUSY;
`ifdef DSTB_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_BUSY: begin
          if (tgt_rdy || tmo) begin
            // Clearing the latch drives the shared buses back to 0.
            req_q <= '0;
            sel_q <= '0;
            state <= ST_IDLE;
          end
`ifdef DSTB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata_mux = '0;
    resp_mux  = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q[i]) begin
        rdata_mux = dstb_dev_data_read_i[64*i +: 64];
        resp_mux  = dstb_dev_resp_i[2*i +: 2];
      end
    end
  end

  assign dstb_dev_data_write_o = req_q.wdata;
  assign dstb_dev_addr_o       = req_q.addr;
  assign dstb_dev_size_o       = req_q.size;
  assign dstb_dev_req_o        = req_q.req;

  always_comb begin
    dstb_ready_o     = 1'b0;
    dstb_data_read_o = '0;
    dstb_resp_o      = DSTB_RESP_OKAY;
    skip_o           = 1'b0;
    if (tgt_rdy) begin
      dstb_ready_o     = 1'b1;
      dstb_data_read_o = rdata_mux;
      dstb_resp_o      = resp_mux;
      skip_o           = |(sel_q & SKIP_MASK);
    end else if (tmo) begin
      dstb_ready_o = 1'b1;
      dstb_resp_o  = DSTB_RESP_SLVERR;
      skip_o       = |(sel_q & SKIP_MASK);
    end else if (state == ST_ERR) begin
      dstb_ready_o = 1'b1;
      dstb_resp_o  = DSTB_RESP_DECERR;
    end
  end

endmodule

// File: tb/tb_mem_dev_dstb.sv
// Self-checking bench for mem_dev_dstb. Two instances share one stimulus:
// dut (default map, DEFAULT_DEV0=1) and dut_nd (DEFAULT_DEV0=0, device 0
// owns 0x8000_0000/0xFFFF_FFFF_8000_0000). use_nd picks which is observed.
module tb_mem_dev_dstb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [63:0]  wdata = '0, addr = '0;
  logic [1:0]   size = '0;
  logic         req = 1'b0;
  logic [2:0]   dev_ready = '0;
  logic [191:0] dev_rdata = '0;
  logic [5:0]   dev_resp = '0;

  logic         m_ready, n_ready, m_req, n_req, m_skip, n_skip;
  logic [63:0]  m_rdata, n_rdata, m_dwdata, n_dwdata, m_daddr, n_daddr;
  logic [1:0]   m_resp, n_resp, m_dsize, n_dsize;
  logic [2:0]   m_dvld, n_dvld;

  int checks = 0;
  int errors = 0;
  bit use_nd = 1'b0;

  always #5 clk = ~clk;

  mem_dev_dstb
`ifdef DSTB_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(4))
`endif
  dut (
    .clk(clk), .rst_n(rst_n), .dstb_valid_i(valid), .dstb_ready_o(m_ready),
    .dstb_data_read_o(m_rdata), .dstb_data_write_i(wdata), .dstb_addr_i(addr),
    .dstb_size_i(size), .dstb_resp_o(m_resp), .dstb_req_i(req),
    .dstb_dev_valid_o(m_dvld), .dstb_dev_ready_i(dev_ready),
    .dstb_dev_data_read_i(dev_rdata), .dstb_dev_data_write_o(m_dwdata),
    .dstb_dev_addr_o(m_daddr), .dstb_dev_size_o(m_dsize),
    .dstb_dev_resp_i(dev_resp), .dstb_dev_req_o(m_req), .skip_o(m_skip)
  );

  mem_dev_dstb #(
    .DEV_BASE({64'h0200_BFF8, 64'h0200_4000, 64'h8000_0000}),
    .DEV_MASK({64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_8000_0000}),
    .DEFAULT_DEV0(1'b0)
`ifdef DSTB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut_nd (
    .clk(clk), .rst_n(rst_n), .dstb_valid_i(valid), .dstb_ready_o(n_ready),
    .dstb_data_read_o(n_rdata), .dstb_data_write_i(wdata), .dstb_addr_i(addr),
    .dstb_size_i(size), .dstb_resp_o(n_resp), .dstb_req_i(req),
    .dstb_dev_valid_o(n_dvld), .dstb_dev_ready_i(dev_ready),
    .dstb_dev_data_read_i(dev_rdata), .dstb_dev_data_write_o(n_dwdata),
    .dstb_dev_addr_o(n_daddr), .dstb_dev_size_o(n_dsize),
    .dstb_dev_resp_i(dev_resp), .dstb_dev_req_o(n_req), .skip_o(n_skip)
  );

  logic        o_ready, o_skip, o_req;
  logic [63:0] o_rdata, o_dwdata, o_daddr;
  logic [1:0]  o_resp, o_dsize;
  logic [2:0]  o_dvld;
  assign o_ready  = use_nd ? n_ready  : m_ready;
  assign o_skip   = use_nd ? n_skip   : m_skip;
  assign o_req    = use_nd ? n_req    : m_req;
  assign o_rdata  = use_nd ? n_rdata  : m_rdata;
  assign o_dwdata = use_nd ? n_dwdata : m_dwdata;
  assign o_daddr  = use_nd ? n_daddr  : m_daddr;
  assign o_resp   = use_nd ? n_resp   : m_resp;
  assign o_dsize  = use_nd ? n_dsize  : m_dsize;
  assign o_dvld   = use_nd ? n_dvld   : m_dvld;

  typedef struct {
    int          cyc;      // cycle of ready pulse, -1 if never seen
    logic [63:0] data;
    logic [1:0]  resp;
    logic        skip;
    logic [2:0]  vld1, vld_rdy;
    logic [63:0] addr1, wdata1;
    logic [1:0]  size1;
    logic        req1;
    bit          stable;   // device buses unchanged over non-ready BUSY cycles
    bit          early;    // ready seen in the accept cycle
    bit          idle_ok;  // buses/ready quiet the cycle after completion
  } obs_t;

  // Address map from the device regions: CLINT regions first (lowest index
  // wins), then device 0 either by default or by its own region.
  function automatic int exp_tgt(input logic [63:0] a, input bit nd);
    if ((a & 64'hFFFF_FFFF_FFFF_FFF8) == 64'h0200_4000) return 1;
    if ((a & 64'hFFFF_FFFF_FFFF_FFF8) == 64'h0200_BFF8) return 2;
    if (!nd) return 0;
    if ((a & 64'hFFFF_FFFF_8000_0000) == 64'h8000_0000) return 0;
    return -1;
  endfunction

  // Drives one request; the device tgt answers lat cycles after accept.
  // With noise, every non-target device holds ready high throughout.
  task automatic do_txn(input logic [63:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, input logic rq, input int tgt,
                        input int lat, input logic [63:0] rd, input logic [1:0] rr,
                        input bit noise, input bit keep, output obs_t o);
    o = '{cyc: -1, stable: 1'b1, default: '0};
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = wd; size = sz; req = rq; dev_ready = '0;
    #1;
    o.early = o_ready;
    for (int c = 1; c <= 40 && o.cyc < 0; c++) begin
      @(negedge clk);
      for (int w = 0; w < 6; w++) dev_rdata[32*w +: 32] = $urandom;
      dev_resp  = 6'($urandom);
      dev_ready = noise ? 3'b111 : 3'b000;
      if (tgt >= 0) begin
        dev_ready[tgt]          = (c == lat + 1);
        dev_rdata[64*tgt +: 64] = rd;
        dev_resp[2*tgt +: 2]    = rr;
      end
      #1;
      if (c == 1) begin
        o.vld1 = o_dvld; o.addr1 = o_daddr; o.wdata1 = o_dwdata;
        o.size1 = o_dsize; o.req1 = o_req;
      end
      if (o_ready) begin
        o.cyc = c; o.data = o_rdata; o.resp = o_resp; o.skip = o_skip;
        o.vld_rdy = o_dvld;
      end else if ({o_dvld, o_daddr, o_dwdata, o_dsize, o_req} !==
                   {o.vld1, o.addr1, o.wdata1, o.size1, o.req1}) begin
        o.stable = 1'b0;
      end
    end
    if (!keep) begin
      @(negedge clk);
      valid = 1'b0; dev_ready = '0;
      #1;
      o.idle_ok = (o_ready === 1'b0) && (o_dvld === 3'b000) &&
                  (o_daddr === 64'h0) && (o_dwdata === 64'h0) && (o_req === 1'b0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; dev_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ready, m_rdata, m_resp, m_dvld, m_dwdata, m_daddr, m_dsize, m_req, m_skip} !== '0) begin
      errors++; $display("FAIL reset_outputs got dvld=%b ready=%b addr=%h exp all zero", m_dvld, m_ready, m_daddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_dev0();
    obs_t o;
    do_txn(64'h8000_0000, 64'h0, 2'd2, 1'b0, 0, 3, 64'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, o);
    checks++; if (o.early) begin errors++; $display("FAIL t1_early got ready at cycle 0 exp none"); end
    checks++; if (o.cyc != 4) begin errors++; $display("FAIL t1_latency got %0d exp 4", o.cyc); end
    checks++; if (o.data !== 64'hDEAD_BEEF || o.resp !== 2'b00 || o.skip !== 1'b0) begin
      errors++; $display("FAIL t1_result got data=%h resp=%b skip=%b exp deadbeef 00 0", o.data, o.resp, o.skip); end
    checks++; if (o.vld1 !== 3'b001 || o.vld_rdy !== 3'b001 || !o.stable) begin
      errors++; $display("FAIL t1_dev_valid got %b/%b stable=%0d exp 001/001 1", o.vld1, o.vld_rdy, o.stable); end
    checks++; if (!o.idle_ok) begin errors++; $display("FAIL t1_idle_after got busy exp idle"); end
  endtask

  task automatic test_write_clint();
    obs_t o;
    do_txn(64'h0200_BFF8, 64'h1234, 2'd3, 1'b1, 2, 2, 64'h0, 2'b00, 1'b0, 1'b0, o);
    checks++; if (o.vld1 !== 3'b100 || o.addr1 !== 64'h0200_BFF8 || o.req1 !== 1'b1 ||
                  o.wdata1 !== 64'h1234 || o.size1 !== 2'd3) begin
      errors++; $display("FAIL t2_bus got vld=%b addr=%h req=%b wd=%h sz=%0d exp 100 0200bff8 1 1234 3",
                         o.vld1, o.addr1, o.req1, o.wdata1, o.size1); end
    checks++; if (!o.stable || o.cyc != 3) begin
      errors++; $display("FAIL t2_hold got stable=%0d cyc=%0d exp 1 3", o.stable, o.cyc); end
    checks++; if (o.skip !== 1'b1) begin errors++; $display("FAIL t2_skip got %b exp 1", o.skip); end
  endtask

  task automatic test_decerr();
    obs_t o;
    use_nd = 1'b1;
    do_txn(64'h1000, 64'h0, 2'd2, 1'b0, exp_tgt(64'h1000, 1'b1), 0, 64'h0, 2'b00, 1'b1, 1'b0, o);
    checks++; if (o.cyc != 1 || o.resp !== 2'b11 || o.data !== 64'h0 || o.skip !== 1'b0) begin
      errors++; $display("FAIL t3_decerr got cyc=%0d resp=%b data=%h skip=%b exp 1 11 0 0", o.cyc, o.resp, o.data, o.skip); end
    checks++; if (o.vld1 !== 3'b000 || !o.idle_ok) begin
      errors++; $display("FAIL t3_no_dev got vld=%b idle=%0d exp 000 1", o.vld1, o.idle_ok); end
    // Device 0's own region still decodes without the default route.
    do_txn(64'h8000_1230, 64'h0, 2'd3, 1'b0, 0, 1, 64'h55AA, 2'b00, 1'b0, 1'b0, o);
    checks++; if (o.cyc != 2 || o.vld1 !== 3'b001 || o.data !== 64'h55AA) begin
      errors++; $display("FAIL t3_dev0_region got cyc=%0d vld=%b data=%h exp 2 001 55aa", o.cyc, o.vld1, o.data); end
    use_nd = 1'b0;
    apply_reset();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    valid = 1'b1; addr = 64'h0200_4000; req = 1'b1; wdata = 64'h77; dev_ready = '0;
    @(negedge clk);
    valid = 1'b0;
    #1;
    checks++; if (m_dvld !== 3'b010) begin errors++; $display("FAIL t4_busy got %b exp 010", m_dvld); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_ready, m_rdata, m_resp, m_dvld, m_dwdata, m_daddr, m_dsize, m_req, m_skip} !== '0) begin
      errors++; $display("FAIL t4_async_reset got dvld=%b addr=%h wd=%h exp all zero", m_dvld, m_daddr, m_dwdata); end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(64'h1_0000_0040, 64'h0, 2'd3, 1'b0, 0, 0, 64'hCAFE, 2'b00, 1'b0, 1'b0, o);
    checks++; if (o.cyc != 1 || o.data !== 64'hCAFE || o.vld1 !== 3'b001) begin
      errors++; $display("FAIL t4_after_reset got cyc=%0d data=%h vld=%b exp 1 cafe 001", o.cyc, o.data, o.vld1); end
  endtask

  task automatic test_ready_noise();
    obs_t o;
    do_txn(64'h0200_4004, 64'h0, 2'd2, 1'b0, 1, 2, 64'h1111_2222, 2'b10, 1'b1, 1'b0, o);
    checks++; if (o.cyc != 3 || o.data !== 64'h1111_2222 || o.resp !== 2'b10 || o.skip !== 1'b1) begin
      errors++; $display("FAIL t5_target_only got cyc=%0d data=%h resp=%b skip=%b exp 3 11112222 10 1",
                         o.cyc, o.data, o.resp, o.skip); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, o3;
    do_txn(64'h0200_4000, 64'hAB, 2'd3, 1'b1, 1, 0, 64'h0, 2'b00, 1'b0, 1'b1, o1);
    do_txn(64'h9000_0000, 64'h0, 2'd1, 1'b0, 0, 1, 64'h4242, 2'b00, 1'b0, 1'b1, o2);
    do_txn(64'h0200_BFFC, 64'h0, 2'd2, 1'b0, 2, 0, 64'h99, 2'b00, 1'b0, 1'b0, o3);
    checks++; if (o1.cyc != 1 || o2.early || o2.cyc != 2 || o3.early || o3.cyc != 1) begin
      errors++; $display("FAIL b2b_timing got %0d/%0d/%0d early=%0d%0d exp 1/2/1 early=00",
                         o1.cyc, o2.cyc, o3.cyc, o2.early, o3.early); end
    checks++; if (o2.vld1 !== 3'b001 || o2.data !== 64'h4242 || o3.vld1 !== 3'b100 || o3.data !== 64'h99) begin
      errors++; $display("FAIL b2b_route got %b:%h %b:%h exp 001:4242 100:99", o2.vld1, o2.data, o3.vld1, o3.data); end
  endtask

  task automatic test_random(input bit nd, input int n);
    obs_t o;
    logic [63:0] a, wd, rd;
    logic [1:0]  rr;
    int t, lat, kind;
    bit noise;
    use_nd = nd;
    for (int k = 0; k < n; k++) begin
      kind = int'($urandom_range(0, 4));
      a = {$urandom, $urandom};
      case (kind)
        1: a = 64'h0200_4000 | 64'(a[2:0]);
        2: a = 64'h0200_BFF8 | 64'(a[2:0]);
        3: a = 64'h0200_4008;
        4: a = {32'h0, 1'b1, a[30:0]};
        default: ;
      endcase
      wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      rr = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      lat = int'($urandom_range(0, 4));
      noise = ($urandom_range(0, 1) != 0);
      t = exp_tgt(a, nd);
      do_txn(a, wd, 2'($urandom), 1'($urandom), t, lat, rd, rr, noise, 1'b0, o);
      checks++;
      if (o.cyc != ((t < 0) ? 1 : lat + 1) || o.early) begin
        errors++; $display("FAIL rnd%0d_%0d_latency got %0d exp %0d", nd, k, o.cyc, (t < 0) ? 1 : lat + 1); end
      checks++;
      if (o.data !== ((t < 0) ? 64'h0 : rd) || o.resp !== ((t < 0) ? 2'b11 : rr) || o.skip !== (t > 0)) begin
        errors++; $display("FAIL rnd%0d_%0d_result got %h/%b/%b addr=%h", nd, k, o.data, o.resp, o.skip, a); end
      checks++;
      if (o.vld1 !== ((t < 0) ? 3'b000 : 3'(1 << t)) || o.addr1 !== ((t < 0) ? 64'h0 : a) ||
          o.wdata1 !== ((t < 0) ? 64'h0 : wd) || !o.stable || !o.idle_ok) begin
        errors++; $display("FAIL rnd%0d_%0d_bus got vld=%b addr=%h stable=%0d idle=%0d tgt=%0d",
                           nd, k, o.vld1, o.addr1, o.stable, o.idle_ok, t); end
    end
    use_nd = 1'b0;
  endtask

`ifdef DSTB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o1, o2;
    do_txn(64'h8000_0000, 64'h0, 2'd3, 1'b0, 0, 100, 64'hFF, 2'b00, 1'b0, 1'b1, o1);
    do_txn(64'h0200_4000, 64'h0, 2'd3, 1'b0, 1, 0, 64'h31, 2'b00, 1'b0, 1'b0, o2);
    checks++; if (o1.cyc != 5 || o1.resp !== 2'b10 || o1.data !== 64'h0 || o1.vld_rdy !== 3'b000) begin
      errors++; $display("FAIL tmo_fire got cyc=%0d resp=%b data=%h vld=%b exp 5 10 0 000",
                         o1.cyc, o1.resp, o1.data, o1.vld_rdy); end
    checks++; if (o2.early || o2.cyc != 1 || o2.data !== 64'h31) begin
      errors++; $display("FAIL tmo_next got cyc=%0d data=%h exp 1 31", o2.cyc, o2.data); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_dev0();
    test_write_clint();
    test_decerr();
    test_reset_mid();
    test_ready_noise();
    test_back_to_back();
    test_random(1'b0, 40);
`ifdef DSTB_TIMEOUT_EN
    test_timeout();
`endif
    apply_reset();
    test_random(1'b1, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
